// File: rtl/note_tone_gen.sv
// Square-wave note generator for the piano speaker: synchronises note codes from the
// beat domain and toggles the speaker pin only at half-period boundaries.
module note_tone_gen #(
  parameter int DIV_SHIFT = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       MUTE,
  input  logic [3:0] note_in,
  output logic       tone_out,
  output logic       playing,
  output logic [3:0] cur_note
);

  // state | meaning
  // IDLE  | silent, waiting for a valid synchronised note code
  // TONE  | square wave running at the pitch of cur_note
  typedef enum logic {IDLE, TONE} state_t;

  state_t      state_q;
  logic [3:0]  s1_q, s2_q, note_q;
  logic [3:0]  cur_note_q;
  logic [17:0] cnt_q;
  logic        tone_q, playing_q;

  logic [17:0] half_d;
  logic [17:0] cnt_d;
  logic        note_valid;
  logic        terminal;

  function automatic logic [17:0] half_of(input logic [3:0] code);
    logic [17:0] base;
    logic [17:0] h;
    case (code)
      4'd1:    base = 18'd191109;
      4'd2:    base = 18'd170262;
      4'd3:    base = 18'd151685;
      4'd4:    base = 18'd143172;
      4'd5:    base = 18'd127551;
      4'd6:    base = 18'd113636;
      4'd7:    base = 18'd101239;
      4'd8:    base = 18'd95557;
      default: base = 18'd0;
    endcase
    h = base >> DIV_SHIFT;
    if (h < 18'd2) h = 18'd2;
    return h;
  endfunction

  assign half_d     = half_of(cur_note_q);
  assign cnt_d      = cnt_q + 18'd1;
  assign note_valid = (note_q >= 4'd1) && (note_q <= 4'd8);
  assign terminal   = (cnt_q == (half_d - 18'd1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_q       <= 4'd0;
      s2_q       <= 4'd0;
      note_q     <= 4'd0;
      state_q    <= IDLE;
      cur_note_q <= 4'd0;
      cnt_q      <= 18'd0;
      tone_q     <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      // Mute also flushes the synchroniser, so a held note restarts with full filter latency.
      if (MUTE) begin
        s1_q   <= 4'd0;
        s2_q   <= 4'd0;
        note_q <= 4'd0;
      end else begin
        s1_q <= note_in;
        s2_q <= s1_q;
        if (s1_q == s2_q) note_q <= s2_q;
      end

      if (MUTE) begin
        state_q    <= IDLE;
        cur_note_q <= 4'd0;
        cnt_q      <= 18'd0;
        tone_q     <= 1'b0;
        playing_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (note_valid) begin
              state_q    <= TONE;
              cur_note_q <= note_q;
              cnt_q      <= 18'd0;
              tone_q     <= 1'b1;
              playing_q  <= 1'b1;
            end
          end
          TONE: begin
            if (!terminal) begin
              cnt_q <= cnt_d;
            end else if (note_valid) begin
              cur_note_q <= note_q;
              cnt_q      <= 18'd0;
              tone_q     <= ~tone_q;
            end else begin
              state_q    <= IDLE;
              cur_note_q <= 4'd0;
              cnt_q      <= 18'd0;
              tone_q     <= 1'b0;
              playing_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tone_out = tone_q;
  assign playing  = playing_q;
  assign cur_note = cur_note_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: expected tone runs (level, length) are queued by the
// stimulus and checked by a negedge monitor as each run ends.
module tb_note_tone_gen;

  localparam int HC4 = 186;
  localparam int HE  = 148;
  localparam int HA  = 110;

  logic       CLK;
  logic       RESET;
  logic       MUTE;
  logic [3:0] note_in;
  logic       tone_out;
  logic       playing;
  logic [3:0] cur_note;

  typedef struct {
    logic lvl;
    int   len;
  } run_t;

  run_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  note_tone_gen #(.DIV_SHIFT(10)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .MUTE     (MUTE),
    .note_in  (note_in),
    .tone_out (tone_out),
    .playing  (playing),
    .cur_note (cur_note)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Run-length monitor: a run closes whenever tone_out changes level.
  int   mon_cyc  = 0;
  int   last_chg = 0;
  logic last_lvl = 1'b0;

  always @(negedge CLK) begin
    run_t e;
    int   len;
    mon_cyc++;
    if (tone_out !== last_lvl) begin
      len = mon_cyc - last_chg;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_edge observed level=%0b len=%0d expected no edge", last_lvl, len);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        assert (last_lvl === e.lvl) else begin
          n_fail++;
          $error("FAIL run_level observed=%0b expected=%0b", last_lvl, e.lvl);
        end
        if (e.len >= 0) begin
          n_checks++;
          assert (len === e.len) else begin
            n_fail++;
            $error("FAIL run_len level=%0b observed=%0d expected=%0d", last_lvl, len, e.len);
          end
        end
      end
      last_lvl = tone_out;
      last_chg = mon_cyc;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic t, input logic p, input logic [3:0] c);
    chk({tag, "_tone"}, {3'b0, tone_out}, {3'b0, t});
    chk({tag, "_playing"}, {3'b0, playing}, {3'b0, p});
    chk({tag, "_cur_note"}, cur_note, c);
  endtask

  task automatic wait_level(input string tag, input logic lvl);
    int n = 0;
    while (tone_out !== lvl && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, {3'b0, tone_out}, {3'b0, lvl});
  endtask

  task automatic push(input logic lvl, input int len);
    run_t r;
    r.lvl = lvl;
    r.len = len;
    exp_q.push_back(r);
  endtask

  initial begin
    RESET   = 1'b1;
    MUTE    = 1'b0;
    note_in = 4'd1;

    // 1: reset holds everything at zero even with a note present
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset", 1'b0, 1'b0, 4'd0);
    end
    RESET   = 1'b0;
    note_in = 4'd0;
    tick(5);
    chk_out("idle_after_reset", 1'b0, 1'b0, 4'd0);

    // 2: C4 start latency and steady half-periods
    push(1'b0, -1);
    push(1'b1, HC4); push(1'b0, HC4);
    push(1'b1, HC4); push(1'b0, HC4);
    push(1'b1, HC4);
    push(1'b0, HE);  push(1'b1, HE);
    push(1'b0, HA);  push(1'b1, HA);
    note_in = 4'd1;
    tick(3);
    chk_out("latency_edge3", 1'b0, 1'b0, 4'd0);
    tick();
    chk_out("latency_edge4", 1'b1, 1'b1, 4'd1);
    wait_level("c4_fall1", 1'b0);
    wait_level("c4_rise2", 1'b1);
    wait_level("c4_fall2", 1'b0);
    wait_level("c4_rise3", 1'b1);

    // 3: change to E mid-high is deferred to the terminal
    tick(50);
    note_in = 4'd3;
    tick(50);
    chk("deferred_cur_note", cur_note, 4'd1);
    wait_level("e_fall", 1'b0);
    chk("e_cur_note", cur_note, 4'd3);
    wait_level("e_rise", 1'b1);
    tick(20);
    note_in = 4'd6;
    wait_level("a_fall1", 1'b0);
    chk("a_cur_note", cur_note, 4'd6);
    wait_level("a_rise", 1'b1);
    wait_level("a_fall2", 1'b0);

    // 4: stop request mid-low finishes the half-period, then idles
    tick(30);
    note_in = 4'd0;
    tick(79);
    chk_out("stop_before_terminal", 1'b0, 1'b1, 4'd6);
    tick();
    chk_out("stop_at_terminal", 1'b0, 1'b0, 4'd0);
    note_in = 4'd12;
    tick(10);
    chk_out("code12_is_none", 1'b0, 1'b0, 4'd0);

    // 5: single-cycle glitch rejected, then MUTE during C4 high
    note_in = 4'd0;
    tick(5);
    note_in = 4'd6;
    tick();
    note_in = 4'd0;
    tick(10);
    chk_out("glitch_ignored", 1'b0, 1'b0, 4'd0);

    push(1'b0, -1);
    push(1'b1, 40);
    push(1'b0, 14);
    push(1'b1, HC4);
    note_in = 4'd1;
    tick(4);
    chk_out("c4_restart", 1'b1, 1'b1, 4'd1);
    tick(39);
    MUTE = 1'b1;
    tick();
    chk_out("mute_next_edge", 1'b0, 1'b0, 4'd0);
    tick(10);
    chk_out("mute_held", 1'b0, 1'b0, 4'd0);
    MUTE = 1'b0;
    tick(3);
    chk_out("unmute_edge3", 1'b0, 1'b0, 4'd0);
    tick();
    chk_out("unmute_edge4", 1'b1, 1'b1, 4'd1);

    // 6: RESET together with MUTE on a terminal cycle
    tick(HC4 - 1);
    chk_out("pre_terminal", 1'b1, 1'b1, 4'd1);
    RESET = 1'b1;
    MUTE  = 1'b1;
    tick();
    chk_out("reset_at_terminal", 1'b0, 1'b0, 4'd0);
    MUTE = 1'b0;
    tick(2);
    push(1'b0, -1);
    RESET = 1'b0;
    tick(3);
    chk_out("post_reset_edge3", 1'b0, 1'b0, 4'd0);
    tick();
    chk_out("post_reset_edge4", 1'b1, 1'b1, 4'd1);
    tick(5);

    chk("scoreboard_empty", exp_q.size() == 0 ? 4'd1 : 4'd0, 4'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
